// File: rtl/fifo_framer_pkg.sv
// Shared types and default sizing for the FIFO-to-stream framer.
package fifo_framer_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_FRAME_LEN = 4;

   typedef enum logic {
      PAYLOAD = 1'b0,
      CSUM    = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_framer.sv
// Groups payload words from an upstream FIFO into frames of FRAME_LEN words,
// each closed by a modular checksum word flagged with data_out_last.
module fifo_framer
   import fifo_framer_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_vld,
   output logic              data_in_rdy,
   input  logic              flush,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_vld,
   input  logic              data_out_rdy,
   output logic              data_out_last,
   output logic [15:0]       frame_cnt
);

   localparam logic [15:0] LP_CNT_LAST = 16'(FRAME_LEN - 1);

   state_t            r_state;
   logic [15:0]       r_cnt;
   logic [DATA_W-1:0] r_csum;
   logic [DATA_W-1:0] r_data;
   logic              r_vld;
   logic              r_last;
   logic [15:0]       r_frame_cnt;

   logic              w_slot_free;
   logic              w_rdy;
   logic              w_accept;

   // The output register can take a new word when empty or being drained this cycle.
   assign w_slot_free = ~r_vld | data_out_rdy;
   assign w_rdy       = (r_state == PAYLOAD) & w_slot_free & rstn;
   assign w_accept    = data_in_vld & w_rdy;

   assign data_in_rdy   = w_rdy;
   assign data_out      = r_data;
   assign data_out_vld  = r_vld;
   assign data_out_last = r_last;
   assign frame_cnt     = r_frame_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= PAYLOAD;
         r_cnt       <= '0;
         r_csum      <= '0;
         r_data      <= '0;
         r_vld       <= 1'b0;
         r_last      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_data <= data_in;
            r_vld  <= 1'b1;
            r_last <= 1'b0;
            r_csum <= r_csum + data_in;
            r_cnt  <= r_cnt + 16'd1;
            if ((r_cnt == LP_CNT_LAST) || flush) begin
               r_state <= CSUM;
            end
         end else if (r_state == CSUM) begin
            if (w_slot_free) begin
               r_data      <= r_csum;
               r_vld       <= 1'b1;
               r_last      <= 1'b1;
               r_csum      <= '0;
               r_cnt       <= '0;
               r_frame_cnt <= r_frame_cnt + 16'd1;
               r_state     <= PAYLOAD;
            end
         end else begin
            if (w_slot_free) begin
               r_vld  <= 1'b0;
               r_last <= 1'b0;
            end
            // An empty frame is never closed, so flush at cnt==0 is dropped.
            if (flush && (r_cnt != '0)) begin
               r_state <= CSUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_framer.sv
// Self-checking bench: an upstream FIFO (queue) feeds fifo_framer; outputs are
// scored against a frame-level model plus directed vectors and corner sequences.
module tb_fifo_framer;

   localparam int FL = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  data_in;
   logic        data_in_vld;
   logic        data_in_rdy;
   logic        flush;
   logic [7:0]  data_out;
   logic        data_out_vld;
   logic        data_out_rdy;
   logic        data_out_last;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   fifo_framer #(
      .DATA_W    (8),
      .FRAME_LEN (FL)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .data_in       (data_in),
      .data_in_vld   (data_in_vld),
      .data_in_rdy   (data_in_rdy),
      .flush         (flush),
      .data_out      (data_out),
      .data_out_vld  (data_out_vld),
      .data_out_rdy  (data_out_rdy),
      .data_out_last (data_out_last),
      .frame_cnt     (frame_cnt)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  fifo_q[$];   // upstream FIFO contents; head drives data_in
   logic [7:0]  frame_q[$];  // words of the currently open frame
   logic [8:0]  exp_q[$];    // expected output stream {last, data}
   logic [8:0]  got_q[$];    // consumed output stream {last, data}
   int unsigned frames_done;
   logic        lat_pend, hold_pend, close_pend, hold_last;
   logic [7:0]  lat_word, hold_data;

   typedef struct {
      int         n;
      logic [7:0] w[4];
      int         mode;   // 0 plain, 1 flush after idle, 2 flush with last accept
      int         en;
      logic [8:0] e[5];
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   function automatic void model_reset();
      fifo_q.delete();
      frame_q.delete();
      exp_q.delete();
      got_q.delete();
      frames_done = 0;
      lat_pend    = 1'b0;
      hold_pend   = 1'b0;
      close_pend  = 1'b0;
   endfunction

   function automatic void model_close();
      logic [7:0] s;
      s = '0;
      foreach (frame_q[i]) s = s + frame_q[i];
      exp_q.push_back({1'b1, s});
      frame_q.delete();
      frames_done++;
      close_pend = 1'b1;
   endfunction

   task automatic drive_eval(input logic f, input logic ordy, input logic gap);
      logic acc, con;
      logic [7:0] w;
      data_in_vld  = (fifo_q.size() > 0) && !gap;
      data_in      = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      flush        = f;
      data_out_rdy = ordy;
      #1;
      if (lat_pend)   check("latency", {data_out_vld, data_out_last, data_out}, {1'b1, 1'b0, lat_word});
      if (hold_pend)  check("hold", {data_out_vld, data_out_last, data_out}, {1'b1, hold_last, hold_data});
      if (close_pend) check("csum_gap_rdy", data_in_rdy, 0);
      lat_pend   = 1'b0;
      hold_pend  = 1'b0;
      close_pend = 1'b0;
      acc = data_in_vld && data_in_rdy;
      con = data_out_vld && data_out_rdy;
      if (data_out_vld && !data_out_rdy) check("stall_rdy", data_in_rdy, 0);
      if (con) begin
         got_q.push_back({data_out_last, data_out});
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %0h, want no word", {data_out_last, data_out});
         end else if ({data_out_last, data_out} !== exp_q[0]) begin
            errors++;
            $display("FAIL out_word: got %0h, want %0h", {data_out_last, data_out}, exp_q[0]);
            void'(exp_q.pop_front());
         end else begin
            void'(exp_q.pop_front());
         end
      end
      if (acc) begin
         w = data_in;
         void'(fifo_q.pop_front());
         exp_q.push_back({1'b0, w});
         frame_q.push_back(w);
         lat_pend = 1'b1;
         lat_word = w;
         if ((frame_q.size() == FL) || f) model_close();
      end else if (f && (frame_q.size() > 0)) begin
         model_close();
      end
      if (data_out_vld && !data_out_rdy) begin
         hold_pend = 1'b1;
         hold_data = data_out;
         hold_last = data_out_last;
      end
   endtask

   task automatic step(input logic f, input logic ordy, input logic gap);
      @(negedge clk);
      drive_eval(f, ordy, gap);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (exp_q.size() > 0 || fifo_q.size() > 0); i++) step(1'b0, 1'b1, 1'b0);
      check("drain_left", exp_q.size() + fifo_q.size(), 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstn         = 1'b0;
      data_in_vld  = 1'b0;
      flush        = 1'b0;
      data_out_rdy = 1'b0;
      #1;
      check("rst_vld",  data_out_vld, 0);
      check("rst_rdy",  data_in_rdy, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_data", {data_out_last, data_out}, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn         = 1'b0;
      data_in      = '0;
      data_in_vld  = 1'b0;
      flush        = 1'b0;
      data_out_rdy = 1'b0;
      model_reset();

      vt[0] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04}, 0, 5, '{9'h001, 9'h002, 9'h003, 9'h004, 9'h10A}};
      vt[1] = '{4, '{8'hFF, 8'hFF, 8'h02, 8'h00}, 0, 5, '{9'h0FF, 9'h0FF, 9'h002, 9'h000, 9'h100}};
      vt[2] = '{2, '{8'h10, 8'h20, 8'h00, 8'h00}, 1, 3, '{9'h010, 9'h020, 9'h130, 9'h000, 9'h000}};
      vt[3] = '{3, '{8'h01, 8'h02, 8'h05, 8'h00}, 2, 4, '{9'h001, 9'h002, 9'h005, 9'h108, 9'h000}};

      for (int v = 0; v < 4; v++) begin
         apply_reset();
         for (int i = 0; i < vt[v].n; i++) begin
            fifo_q.push_back(vt[v].w[i]);
            step((vt[v].mode == 2) && (i == vt[v].n - 1), 1'b1, 1'b0);
         end
         if (vt[v].mode == 1) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);   // second flush lands in the checksum cycle
         end
         drain();
         step(1'b1, 1'b1, 1'b0);       // flush on an empty frame
         repeat (3) step(1'b0, 1'b1, 1'b0);
         check("vec_n_out", got_q.size(), vt[v].en);
         for (int i = 0; i < vt[v].en && i < got_q.size(); i++) check("vec_word", got_q[i], vt[v].e[i]);
         check("vec_frame_cnt", frame_cnt, 1);
      end

      // Backpressure: hold 02 on the output for 5 cycles.
      apply_reset();
      fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("bp_data", {data_out_vld, data_out}, {1'b1, 8'h02});
         check("bp_rdy", data_in_rdy, 0);
      end
      drain();
      check("bp_n_out", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) check("bp_word", got_q[i], vt[0].e[i]);
      check("bp_frame_cnt", frame_cnt, 1);

      // Reset mid-frame, then accept on the very first edge after release.
      apply_reset();
      fifo_q = '{8'h01, 8'h02};
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_vld", data_out_vld, 0);
      check("midrst_rdy", data_in_rdy, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn   = 1'b1;
      fifo_q = '{8'h01, 8'h01, 8'h01, 8'h01};
      drive_eval(1'b0, 1'b1, 1'b0);
      check("first_edge_rdy", data_in_rdy, 1);
      drain();
      check("midrst_n_out", got_q.size(), 5);
      if (got_q.size() == 5) check("midrst_csum", got_q[4], 9'h104);
      check("midrst_frame_cnt", frame_cnt, 1);

      // Randomised traffic against the frame-level model.
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0);
      end
      for (int i = 0; i < 8 && frame_q.size() > 0; i++) step(1'b1, 1'b1, 1'b1);
      drain();
      check("rand_frame_cnt", frame_cnt, 16'(frames_done));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
